load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameters: none; widths come from the shared defines (WORD_WIDTH=32, RF_ADDR_WIDTH=5).
REQ-003 clk  in  1  clock, rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  execute stage presents a memory op.
REQ-006 req_ready  out  1  unit can accept an op this cycle.
REQ-007 is_store  in  1  1=store, 0=load.
REQ-008 funct3  in  3  RV32I width/sign code.
REQ-009 addr  in  32  byte address.
REQ-010 store_data  in  32  rs2 value.
REQ-011 rd  in  5  load destination register.
REQ-012 mem_req  out  1  data-memory request.
REQ-013 mem_we, mem_be, mem_addr, mem_wdata  out  1/4/32/32  write flag, byte enables, word-aligned address, lane-shifted data.
REQ-014 mem_gnt  in  1  memory accepted the request.
REQ-015 mem_rvalid, mem_rdata  in  1/32  response strobe and read word.
REQ-016 wb_we, wb_addr, wb_data  out  1/5/32  register-file write port.
REQ-017 stall  out  1  pipeline must hold.
REQ-018 fault  out  1  one-cycle pulse: misaligned or illegal op.

Function
REQ-019 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE; req_ready=1 only in IDLE; stall=(state!=IDLE).
REQ-020 Accept in IDLE when req_valid: capture is_store, funct3, addr, store_data and rd.
REQ-021 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others are illegal.
REQ-022 Halfword with addr[0]=1, word with addr[1:0]!=0, or illegal funct3: no memory access, fault=1 the next cycle, remain IDLE.
REQ-023 REQ: mem_req=1 with registered mem_* outputs held stable until mem_gnt; on mem_gnt go to WAIT.
REQ-024 mem_addr={addr[31:2],2'b00}; mem_be: byte=1<<addr[1:0], half=4'b0011<<addr[1:0], word=4'b1111.
REQ-025 Store data replicated into lanes: byte into all 4 lanes, half into both halves.
REQ-026 WAIT: on mem_rvalid go to IDLE; mem_rvalid in IDLE or REQ is ignored.
REQ-027 Load: in the cycle after mem_rvalid, wb_we=1 for exactly one cycle; wb_addr=rd; wb_data = the selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-028 Load with rd=0 performs the access but never asserts wb_we.
REQ-029 Store: wb_we stays 0; completion on mem_rvalid; mem_rdata is ignored.
REQ-030 Latency with same-cycle grant: accept at edge 0; REQ in cycle 1; WAIT in cycle 2 with rvalid; wb_we in cycle 3 with req_ready=1 (back-to-back allowed).
REQ-031 wb_addr and wb_data hold their last values when wb_we=0.

Reset
REQ-032 On rst: state=IDLE; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_we=0, wb_addr=0, wb_data=0, fault=0; req_ready=1; stall=0.
REQ-033 rst mid-transaction aborts immediately (mem_req drops asynchronously); a later mem_rvalid produces no writeback.

Structure
REQ-034 Shared package holds the funct3 load/store encodings and the FSM state enum.
REQ-035 One sub-module, lsu_align (combinational): byte-enable/store-lane generation and load lane extract plus extension.

Verification
REQ-036 LW addr=0x100, mem_rdata=0x89ABCDEF, gnt and rvalid immediate -> mem_be=1111, wb_we pulse in cycle 3, wb_data=0x89ABCDEF.
REQ-037 LB addr=0x103, rdata=0x80xxxxxx -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102, rdata=0xBEEF0000 -> 0x0000BEEF.
REQ-038 SB addr=0x101, store_data=0x000000AA -> mem_we=1, mem_be=0010, mem_wdata=0xAAAAAAAA, no wb_we.
REQ-039 LW addr=0x102 or funct3=011 -> fault pulse, mem_req never asserted, req_ready stays 1.
REQ-040 mem_gnt delayed 3 cycles -> mem_req and mem_* stable for 4 cycles, stall=1 throughout.
REQ-041 rst asserted in WAIT, then mem_rvalid=1 after release -> state IDLE, wb_we=0, mem_req=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I funct3 memory
// encodings, FSM state type and the operation legality check.
package load_store_unit_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int RF_ADDR_WIDTH = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

  // Legal encoding and natural alignment; unsigned variants exist only for loads.
  function automatic logic op_legal(input logic       is_st,
                                    input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_st;
      F3_HU:   ok = ~is_st & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store lane replication, plus
// load lane extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]            st_size,
  input  logic [1:0]            st_off,
  input  logic [WORD_WIDTH-1:0] st_data,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_off,
  input  logic [WORD_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] ld_data
);

  logic [WORD_WIDTH-1:0] lane_s;

  // Store side: enables follow the byte offset, data is replicated across lanes.
  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_size)
      2'b00: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << st_off;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  // Load side: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane_s  = rdata >> {ld_off, 3'b000};
    ld_data = lane_s;
    case (ld_funct3)
      F3_B:    ld_data = {{24{lane_s[7]}}, lane_s[7:0]};
      F3_H:    ld_data = {{16{lane_s[15]}}, lane_s[15:0]};
      F3_BU:   ld_data = {24'h00_0000, lane_s[7:0]};
      F3_HU:   ld_data = {16'h0000, lane_s[15:0]};
      default: ld_data = lane_s;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding data-memory access with a
// request/grant/response handshake and register-file writeback for loads.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     is_store,
  input  logic [2:0]               funct3,
  input  logic [WORD_WIDTH-1:0]    addr,
  input  logic [WORD_WIDTH-1:0]    store_data,
  input  logic [RF_ADDR_WIDTH-1:0] rd,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [3:0]               mem_be,
  output logic [WORD_WIDTH-1:0]    mem_addr,
  output logic [WORD_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [WORD_WIDTH-1:0]    mem_rdata,
  output logic                     wb_we,
  output logic [RF_ADDR_WIDTH-1:0] wb_addr,
  output logic [WORD_WIDTH-1:0]    wb_data,
  output logic                     stall,
  output logic                     fault
);

  lsu_state_e state_r;
  lsu_state_e state_nxt_s;

  logic                     accept_s;
  logic                     legal_s;
  logic                     go_s;
  logic                     is_store_r;
  logic [2:0]               funct3_r;
  logic [1:0]               off_r;
  logic [RF_ADDR_WIDTH-1:0] rd_r;
  logic [3:0]               be_s;
  logic [WORD_WIDTH-1:0]    wdata_s;
  logic [WORD_WIDTH-1:0]    ld_data_s;

  assign accept_s  = (state_r == ST_IDLE) & req_valid;
  assign legal_s   = op_legal(is_store, funct3, addr[1:0]);
  assign go_s      = accept_s & legal_s;
  assign req_ready = (state_r == ST_IDLE);
  assign stall     = (state_r != ST_IDLE);

  lsu_align u_align (
    .st_size   (funct3[1:0]),
    .st_off    (addr[1:0]),
    .st_data   (store_data),
    .ld_funct3 (funct3_r),
    .ld_off    (off_r),
    .rdata     (mem_rdata),
    .be        (be_s),
    .wdata     (wdata_s),
    .ld_data   (ld_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; responses outside WAIT are simply not looked at.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s) state_nxt_s = ST_REQ;
        else      state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (mem_gnt) state_nxt_s = ST_WAIT;
        else         state_nxt_s = ST_REQ;
      end
      ST_WAIT: begin
        if (mem_rvalid) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Capture the op attributes needed when the response returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_r <= 1'b0;
      funct3_r   <= 3'b000;
      off_r      <= 2'b00;
      rd_r       <= '0;
    end else if (go_s) begin
      is_store_r <= is_store;
      funct3_r   <= funct3;
      off_r      <= addr[1:0];
      rd_r       <= rd;
    end
  end

  // Memory request outputs, loaded on accept and frozen until granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_be    <= be_s;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata_s;
          end
        end
        ST_REQ: begin
          if (mem_gnt) mem_req <= 1'b0;
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

  // Fault pulse for a rejected op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else begin
      fault <= accept_s & ~legal_s;
    end
  end

  // Load writeback; x0 is never written and address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if ((state_r == ST_WAIT) && mem_rvalid && !is_store_r &&
                 (rd_r != '0)) begin
      wb_we   <= 1'b1;
      wb_addr <= rd_r;
      wb_data <= ld_data_s;
    end else begin
      wb_we   <= 1'b0;
    end
  end

endmodule
